// File: rtl/line_drawer.sv
// line_drawer: accepts a line (x0,y0)->(x1,y1) on start/ready and rasterises it
// with integer Bresenham, presenting one pixel per beat on a valid/ready port.
// Optional build macro LINE_DRAWER_CLIP_EN: off-screen pixels are skipped
// (pix_valid low, one beat each) instead of being presented.
module line_drawer #(
   parameter int WIDTH    = 11,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             ready,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] y0,
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] y1,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic [WIDTH-1:0] pix_x,
   output logic [WIDTH-1:0] pix_y,
   output logic             done
);

   // Error terms need two extra bits so |dx|+|dy| never overflows.
   localparam int EW = WIDTH + 2;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_FIN} state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]    cur_x, cur_y, end_x, end_y;
   logic signed [EW-1:0] dx, dy, err;
   logic                sx_neg, sy_neg;

   logic signed [EW-1:0] diff_x, diff_y, abs_dx, abs_dy;
   logic signed [EW:0]   e2;
   logic signed [EW-1:0] dx_term, dy_term, err_nxt;
   logic                 step_x, step_y, at_end, clipped, beat;

   // A screen larger than the coordinate range would make clipping meaningless.
   if (SCREEN_W > (1 << WIDTH) || SCREEN_H > (1 << WIDTH)) begin : g_bad_screen
      $error("line_drawer: screen size exceeds coordinate range");
   end

`ifdef LINE_DRAWER_CLIP_EN
   assign clipped = ({{(32-WIDTH){1'b0}}, cur_x} >= 32'(SCREEN_W)) ||
                    ({{(32-WIDTH){1'b0}}, cur_y} >= 32'(SCREEN_H));
`else
   assign clipped = 1'b0;
`endif

   // A beat completes when the writer takes the pixel, or the pixel is clipped.
   assign beat   = (state == S_DRAW) && (pix_ready || clipped);
   assign at_end = (cur_x == end_x) && (cur_y == end_y);
   assign pix_x  = cur_x;
   assign pix_y  = cur_y;

   // Setup magnitudes and the per-beat Bresenham step decision.
   always_comb begin
      diff_x  = $signed({2'b00, end_x}) - $signed({2'b00, cur_x});
      diff_y  = $signed({2'b00, end_y}) - $signed({2'b00, cur_y});
      abs_dx  = diff_x[EW-1] ? -diff_x : diff_x;
      abs_dy  = diff_y[EW-1] ? -diff_y : diff_y;
      e2      = {err, 1'b0};
      step_x  = e2 >= $signed({dy[EW-1], dy});
      step_y  = e2 <= $signed({dx[EW-1], dx});
      dy_term = step_x ? dy : {EW{1'b0}};
      dx_term = step_y ? dx : {EW{1'b0}};
      err_nxt = err + dy_term + dx_term;
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start)           state_nxt = S_SETUP;
         S_SETUP:                      state_nxt = S_DRAW;
         S_DRAW:  if (beat && at_end)  state_nxt = S_FIN;
         S_FIN:                        state_nxt = S_IDLE;
         default:                      state_nxt = S_IDLE;
      endcase
   end

   // Moore outputs decoded from state.
   always_comb begin
      ready     = 1'b0;
      pix_valid = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: ready     = 1'b1;
         S_DRAW: pix_valid = !clipped;
         S_FIN:  done      = 1'b1;
         default: ;
      endcase
   end

   // Datapath: endpoints load on accept (cur doubles as the start point),
   // SETUP derives deltas, DRAW walks cur towards the end point.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_x  <= '0;
         cur_y  <= '0;
         end_x  <= '0;
         end_y  <= '0;
         dx     <= '0;
         dy     <= '0;
         err    <= '0;
         sx_neg <= 1'b0;
         sy_neg <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               cur_x <= x0;
               cur_y <= y0;
               end_x <= x1;
               end_y <= y1;
            end
            S_SETUP: begin
               dx     <= abs_dx;
               dy     <= -abs_dy;
               err    <= abs_dx - abs_dy;
               sx_neg <= !(cur_x < end_x);
               sy_neg <= !(cur_y < end_y);
            end
            S_DRAW: if (beat && !at_end) begin
               err <= err_nxt;
               if (step_x) cur_x <= sx_neg ? cur_x - ONE : cur_x + ONE;
               if (step_y) cur_y <= sy_neg ? cur_y - ONE : cur_y + ONE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_line_drawer.sv
// tb_line_drawer: directed lines against an integer reference of the line
// algorithm, with a per-cycle output compare and literal pins on key lines.
module tb_line_drawer;
   localparam int W = 11;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         pix_ready = 1'b1;
   logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic         ready, pix_valid, done;
   logic [W-1:0] pix_x, pix_y;

   line_drawer #(.WIDTH(W), .SCREEN_W(640), .SCREEN_H(480)) dut (
      .clk(clk), .reset(reset), .start(start), .ready(ready),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {int x; int y;} pt_t;
   pt_t exp_q[$];
   int  log_x[$], log_y[$], log_rel[$];
   int  cyc = 0, acc_cyc = 0, done_rel = -1, ready_rel = -1, done_cnt = 0;
   int  checks = 0, errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Reference: every point the line passes through, from the algorithm's rules.
   task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
      int x, y, dx, dy, sx, sy, e, e2;
      x = ax0; y = ay0;
      dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
      dy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
      sx = (ax0 < ax1) ? 1 : -1;
      sy = (ay0 < ay1) ? 1 : -1;
      e  = dx + dy;
      forever begin
`ifdef LINE_DRAWER_CLIP_EN
         if (x < 640 && y < 480) exp_q.push_back('{x, y});
`else
         exp_q.push_back('{x, y});
`endif
         if (x == ax1 && y == ay1) break;
         e2 = 2 * e;
         if (e2 >= dy) begin e += dy; x += sx; end
         if (e2 <= dx) begin e += dx; y += sy; end
      end
   endtask

   // Per-cycle compare of the pixel port and done against the reference.
   always @(negedge clk) begin
      if (reset) begin
         if (start && ready) begin
            acc_cyc = cyc; done_rel = -1; ready_rel = -1;
            log_x.delete(); log_y.delete(); log_rel.delete();
         end else if (ready && ready_rel < 0) ready_rel = cyc - acc_cyc;
         if (pix_valid) begin
            if (exp_q.size() == 0) chk("unexpected_pixel", 1, 0);
            else begin
               chk("pix_x", int'(pix_x), exp_q[0].x);
               chk("pix_y", int'(pix_y), exp_q[0].y);
            end
            if (pix_ready) begin
               log_x.push_back(int'(pix_x)); log_y.push_back(int'(pix_y));
               log_rel.push_back(cyc - acc_cyc);
               if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
         end
         if (done) begin
            chk("done_with_pixels_left", exp_q.size(), 0);
            done_cnt++;
            done_rel = cyc - acc_cyc;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic launch(input int ax0, input int ay0, input int ax1, input int ay1);
      int n = 0;
      while (!ready && n < 100) begin step(); n++; end
      if (!ready) chk("ready_timeout", 0, 1);
      model(ax0, ay0, ax1, ay1);
      x0 = W'(ax0); y0 = W'(ay0); x1 = W'(ax1); y1 = W'(ay1);
      start = 1'b1;
      step();
      start = 1'b0;
      // Endpoint changes after accept must not matter.
      x0 = W'(7); y0 = W'(9); x1 = W'(3); y1 = W'(4);
   endtask

   task automatic wait_done(input int d0);
      int n = 0;
      while (done_cnt == d0 && n < 3000) begin step(); n++; end
      if (done_cnt == d0) chk("done_timeout", 0, 1);
      step(); step();
      chk("done_count", done_cnt, d0 + 1);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic draw(input int ax0, input int ay0, input int ax1, input int ay1);
      int d0;
      d0 = done_cnt;
      launch(ax0, ay0, ax1, ay1);
      wait_done(d0);
   endtask

   initial begin
      int bad, d0, hx, hy, n;
      #2 reset = 1'b0;
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_pix_x", int'(pix_x), 0);
      chk("rst_pix_y", int'(pix_y), 0);
      step(); step();
      reset = 1'b1;
      step();

      // Horizontal full-width line: latency and sequence pinned literally.
      draw(0, 0, 639, 0);
      chk("h_count", log_x.size(), 640);
      chk("h_first_rel", log_rel[0], 2);
      chk("h_last_rel", log_rel[639], 641);
      chk("h_done_rel", done_rel, 642);
      chk("h_ready_rel", ready_rel, 643);
      bad = 0;
      for (int i = 0; i < 640; i++) if (log_x[i] != i || log_y[i] != 0) bad++;
      chk("h_seq", bad, 0);

      // Single point: one pixel at N+2, done at N+2+P with P=1.
      draw(5, 5, 5, 5);
      chk("pt_count", log_x.size(), 1);
      chk("pt_x", log_x[0], 5);
      chk("pt_y", log_y[0], 5);
      chk("pt_done_rel", done_rel, 3);

      // Steep line, hand-traced pixel list.
      draw(0, 0, 2, 5);
      chk("steep_count", log_x.size(), 6);
      begin
         int ex[6] = '{0, 0, 1, 1, 2, 2};
         bad = 0;
         for (int i = 0; i < 6 && i < log_x.size(); i++)
            if (log_x[i] != ex[i] || log_y[i] != i) bad++;
         chk("steep_seq", bad, 0);
      end

      // Diagonal, both axes decrementing.
      draw(10, 10, 0, 0);
      chk("diag_count", log_x.size(), 11);
      bad = 0;
      for (int i = 0; i < log_x.size(); i++)
         if (log_x[i] != 10 - i || log_y[i] != 10 - i) bad++;
      chk("diag_seq", bad, 0);

      // Long diagonal with a 3-cycle writer stall at pixel 100 and a stray start.
      d0 = done_cnt;
      launch(0, 0, 639, 479);
      n = 0;
      while (log_x.size() < 100 && n < 500) begin step(); n++; end
      chk("stall_reached", log_x.size(), 100);
      pix_ready = 1'b0;
      hx = int'(pix_x); hy = int'(pix_y);
      start = 1'b1; x0 = W'(5); y0 = W'(5); x1 = W'(6); y1 = W'(6);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_valid", pix_valid, 1);
         chk("stall_x", int'(pix_x), hx);
         chk("stall_y", int'(pix_y), hy);
         step();
      end
      pix_ready = 1'b1;
      start = 1'b0;
      wait_done(d0);
      chk("long_count", log_x.size(), 640);
      chk("long_last_x", log_x[log_x.size()-1], 639);
      chk("long_last_y", log_y[log_y.size()-1], 479);

      // Reset mid-line: line abandoned at once, no done.
      d0 = done_cnt;
      launch(0, 0, 639, 0);
      n = 0;
      while (log_x.size() < 50 && n < 200) begin step(); n++; end
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", pix_valid, 0);
      chk("mid_rst_ready", ready, 1);
      chk("mid_rst_done", done, 0);
      exp_q.delete();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("in_rst_done", done, 0);
         step();
      end
      reset = 1'b1;
      step(); step();
      chk("no_done_after_rst", done_cnt, d0);
      draw(1, 1, 3, 1);
      chk("post_rst_count", log_x.size(), 3);
      bad = 0;
      for (int i = 0; i < log_x.size(); i++)
         if (log_x[i] != 1 + i || log_y[i] != 1) bad++;
      chk("post_rst_seq", bad, 0);

      // Line crossing the right screen edge.
      draw(630, 0, 650, 0);
`ifdef LINE_DRAWER_CLIP_EN
      chk("edge_count", log_x.size(), 10);
      chk("edge_last_x", log_x[log_x.size()-1], 639);
`else
      chk("edge_count", log_x.size(), 21);
      chk("edge_last_x", log_x[log_x.size()-1], 650);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
